// File: rtl/axi_lite_bram_responder.sv
// axi_lite_bram_responder: AXI4-Lite slave in front of a single-port BRAM.
// One transaction in flight; reads and writes alternate under contention.
module axi_lite_bram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 4096
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [2:0] {
    IDLE, WR, RD_ISSUE, RD_CAPTURE, BRESP, RRESP
  } state_t;

  localparam logic [30:0] WORDS = 31'(MEM_WORDS);

  state_t      state;
  logic        ar_full, aw_full, w_full;
  logic [31:0] ar_addr, aw_addr, w_data;
  logic [3:0]  w_strb;
  logic        last_wr;

  logic [31:0] ar_off, aw_off;
  logic        ar_ok, aw_ok;
  logic        wr_elig, rd_elig;
  logic        grant_rd, grant_wr;
  logic        rd_done, wr_done;

  assign s_axi_arready = sys_rst_n & ~ar_full;
  assign s_axi_awready = sys_rst_n & ~aw_full;
  assign s_axi_wready  = sys_rst_n & ~w_full;

  // offset[31:2] < MEM_WORDS is the same as offset < 4*MEM_WORDS
  assign ar_off = ar_addr - BASE_ADDR;
  assign aw_off = aw_addr - BASE_ADDR;
  assign ar_ok  = {1'b0, ar_off} < {WORDS, 2'b00};
  assign aw_ok  = {1'b0, aw_off} < {WORDS, 2'b00};

  assign wr_elig  = aw_full & w_full;
  assign rd_elig  = ar_full;
  assign grant_rd = (state == IDLE) & rd_elig
                  & (~wr_elig | last_wr);
  assign grant_wr = (state == IDLE) & wr_elig & ~grant_rd;
  assign rd_done  = (state == RRESP) & s_axi_rready;
  assign wr_done  = (state == BRESP) & s_axi_bready;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ar_full <= 1'b0;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      ar_addr <= '0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (s_axi_arvalid && s_axi_arready) begin
        ar_full <= 1'b1;
        ar_addr <= s_axi_araddr;
      end else if (rd_done) begin
        ar_full <= 1'b0;
      end
      if (s_axi_awvalid && s_axi_awready) begin
        aw_full <= 1'b1;
        aw_addr <= s_axi_awaddr;
      end else if (wr_done) begin
        aw_full <= 1'b0;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_full <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end else if (wr_done) begin
        w_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      last_wr      <= 1'b1;
      mem_en       <= 1'b0;
      mem_we       <= '0;
      mem_addr     <= '0;
      mem_din      <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= '0;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= '0;
      s_axi_rdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_rd) begin
            last_wr <= 1'b0;
            if (ar_ok) begin
              state    <= RD_ISSUE;
              mem_en   <= 1'b1;
              mem_we   <= '0;
              mem_addr <= ar_off[31:2];
            end else begin
              state        <= RRESP;
              s_axi_rvalid <= 1'b1;
              s_axi_rresp  <= 2'b10;
              s_axi_rdata  <= '0;
            end
          end else if (grant_wr) begin
            last_wr <= 1'b1;
            if (aw_ok) begin
              state    <= WR;
              mem_en   <= 1'b1;
              mem_we   <= w_strb;
              mem_addr <= aw_off[31:2];
              mem_din  <= w_data;
            end else begin
              state        <= BRESP;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= 2'b10;
            end
          end
        end
        WR: begin
          mem_en       <= 1'b0;
          mem_we       <= '0;
          s_axi_bvalid <= 1'b1;
          s_axi_bresp  <= 2'b00;
          state        <= BRESP;
        end
        RD_ISSUE: begin
          mem_en <= 1'b0;
          state  <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
          s_axi_rdata  <= mem_dout;
          s_axi_rvalid <= 1'b1;
          s_axi_rresp  <= 2'b00;
          state        <= RRESP;
        end
        BRESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= '0;
            state        <= IDLE;
          end
        end
        RRESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= '0;
            s_axi_rdata  <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_bram_responder.sv
// tb_axi_lite_bram_responder: directed AXI4-Lite traffic against a
// transaction-level memory model, with per-cycle output checks.
module tb_axi_lite_bram_responder;
  localparam logic [31:0] BASE = 32'h0;
  localparam int MW = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  axi_lite_bram_responder #(
    .BASE_ADDR(BASE),
    .MEM_WORDS(MW)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .s_axi_araddr(araddr),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata(rdata),
    .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid),
    .s_axi_rready(rready),
    .s_axi_awaddr(awaddr),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata(wdata),
    .s_axi_wstrb(wstrb),
    .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bresp(bresp),
    .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 4K-word BRAM; upper address bits ignored so stray writes alias visibly
  logic [31:0] bram [MW];
  logic [31:0] ref_mem [MW];
  logic [31:0] bw;
  always @(posedge clk) begin
    if (mem_en) begin
      bw = bram[mem_addr[11:0]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) bw[8*b +: 8] = mem_din[8*b +: 8];
      bram[mem_addr[11:0]] <= bw;
      mem_dout <= bram[mem_addr[11:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // transaction-level model
  logic [33:0] exp_r_q [$];
  logic [1:0]  exp_b_q [$];
  logic [65:0] exp_w_q [$];

  function automatic logic in_win(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off >> 2) < MW;
  endfunction

  function automatic logic [29:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[31:2];
  endfunction

  task automatic exp_read(input logic [31:0] a);
    if (in_win(a)) exp_r_q.push_back({2'b00, ref_mem[widx(a)]});
    else exp_r_q.push_back({2'b10, 32'h0});
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    logic [31:0] m;
    if (in_win(a)) begin
      if (s != 4'b0) exp_w_q.push_back({widx(a), s, d});
      m = ref_mem[widx(a)];
      for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
      ref_mem[widx(a)] = m;
      exp_b_q.push_back(2'b00);
    end else begin
      exp_b_q.push_back(2'b10);
    end
  endtask

  // per-cycle compare and event monitor
  logic        rv_q = 0, bv_q = 0, rr_q = 0, br_q = 0;
  logic [31:0] rd_q = '0;
  logic [1:0]  rs_q = '0, bs_q = '0;
  int en_cnt = 0, we_cyc = -1, rv_cyc = -1, bv_cyc = -1, rv_rises = 0;
  int order [$];
  logic [65:0] ew;
  logic [33:0] er;
  logic [1:0]  eb;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!mem_en) chk("we_without_en", 32'(mem_we), 32'h0);
      if (mem_en) en_cnt++;
      if (mem_en && mem_we != 4'b0) begin
        we_cyc = cyc;
        chk("wr_expected", 32'(exp_w_q.size() != 0), 32'h1);
        if (exp_w_q.size() != 0) begin
          ew = exp_w_q.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(ew[65:36]));
          chk("wr_we", 32'(mem_we), 32'(ew[35:32]));
          chk("wr_din", mem_din, ew[31:0]);
        end
      end
      if (rvalid && !rv_q) begin
        rv_cyc = cyc; rv_rises++; order.push_back(0);
      end
      if (bvalid && !bv_q) begin
        bv_cyc = cyc; order.push_back(1);
      end
      if (rvalid && rv_q && !rr_q) begin
        chk("rdata_hold", rdata, rd_q);
        chk("rresp_hold", 32'(rresp), 32'(rs_q));
      end
      if (bvalid && bv_q && !br_q) chk("bresp_hold", 32'(bresp), 32'(bs_q));
      if (rvalid && rready) begin
        chk("rd_expected", 32'(exp_r_q.size() != 0), 32'h1);
        if (exp_r_q.size() != 0) begin
          er = exp_r_q.pop_front();
          chk("rresp", 32'(rresp), 32'(er[33:32]));
          chk("rdata", rdata, er[31:0]);
        end
      end
      if (bvalid && bready) begin
        chk("b_expected", 32'(exp_b_q.size() != 0), 32'h1);
        if (exp_b_q.size() != 0) begin
          eb = exp_b_q.pop_front();
          chk("bresp", 32'(bresp), 32'(eb));
        end
      end
    end
    rv_q = rst_n & rvalid;
    bv_q = rst_n & bvalid;
    rr_q = rready;
    br_q = bready;
    rd_q = rdata;
    rs_q = rresp;
    bs_q = bresp;
  end

  // stimulus helpers, entered and left at posedge+1
  task automatic hs_ar(input logic [31:0] a);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    chk("arready", 32'(arready), 32'h1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic hs_aw(input logic [31:0] a);
    int n = 0;
    awaddr = a; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    chk("awready", 32'(awready), 32'h1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic hs_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < 50) begin @(negedge clk); n++; end
    chk("wready", 32'(wready), 32'h1);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic hs_wr(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    fork
      hs_aw(a);
      hs_w(d, s);
    join
  endtask

  logic [31:0] last_rdata;
  logic [1:0]  last_rresp, last_bresp;

  task automatic wait_r();
    int n = 0;
    @(negedge clk);
    while (!rvalid && n < 40) begin @(negedge clk); n++; end
    chk("rvalid_seen", 32'(rvalid), 32'h1);
    last_rdata = rdata; last_rresp = rresp;
    @(posedge clk); #1;
  endtask

  task automatic wait_b();
    int n = 0;
    @(negedge clk);
    while (!bvalid && n < 40) begin @(negedge clk); n++; end
    chk("bvalid_seen", 32'(bvalid), 32'h1);
    last_bresp = bresp;
    @(posedge clk); #1;
  endtask

  task automatic chk_rst_vals();
    chk("rst_arready", 32'(arready), 32'h0);
    chk("rst_awready", 32'(awready), 32'h0);
    chk("rst_wready", 32'(wready), 32'h0);
    chk("rst_bvalid", 32'(bvalid), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_bresp", 32'(bresp), 32'h0);
    chk("rst_rresp", 32'(rresp), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_din", mem_din, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; arvalid = 0; awvalid = 0; wvalid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst_vals();
    exp_r_q.delete(); exp_b_q.delete(); exp_w_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_arready", 32'(arready), 32'h1);
    chk("rel_awready", 32'(awready), 32'h1);
    chk("rel_wready", 32'(wready), 32'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, ka, en0, rv0, n;
    for (int i = 0; i < MW; i++) begin
      bram[i] = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    @(posedge clk); #1;
    do_reset();

    // write and read back, AW and W in the same cycle
    exp_write(32'h10, 32'hDEAD_BEEF, 4'hF);
    k = cyc;
    hs_wr(32'h10, 32'hDEAD_BEEF, 4'hF);
    wait_b();
    chk("wr_latency", 32'(we_cyc - k), 32'd2);
    chk("b_latency", 32'(bv_cyc - k), 32'd3);
    chk("bresp_ok", 32'(last_bresp), 32'h0);
    exp_read(32'h10);
    k = cyc;
    hs_ar(32'h10);
    wait_r();
    chk("r_latency", 32'(rv_cyc - k), 32'd4);
    chk("rd_10", last_rdata, 32'hDEAD_BEEF);

    // W three cycles ahead of AW, single byte lane
    exp_write(32'h10, 32'h0000_AB00, 4'b0010);
    chk("model_10", ref_mem[4], 32'hDEAD_ABEF);
    hs_w(32'h0000_AB00, 4'b0010);
    en0 = en_cnt;
    repeat (2) begin @(posedge clk); #1; end
    chk("no_early_en", 32'(en_cnt), 32'(en0));
    ka = cyc;
    hs_aw(32'h10);
    wait_b();
    chk("late_aw_latency", 32'(we_cyc - ka), 32'd2);
    exp_read(32'h10);
    hs_ar(32'h10);
    wait_r();
    chk("rd_byte1", last_rdata, 32'hDEAD_ABEF);

    // zero strobe still enables the BRAM and answers OKAY
    en0 = en_cnt;
    exp_write(32'h20, 32'hFFFF_FFFF, 4'b0000);
    hs_wr(32'h20, 32'hFFFF_FFFF, 4'b0000);
    wait_b();
    chk("strb0_en", 32'(en_cnt - en0), 32'd1);
    chk("strb0_bresp", 32'(last_bresp), 32'h0);
    exp_read(32'h20);
    hs_ar(32'h20);
    wait_r();
    chk("strb0_rd", last_rdata, 32'hA500_0008);

    // first address past the window
    en0 = en_cnt;
    exp_read(32'h4000);
    k = cyc;
    hs_ar(32'h4000);
    wait_r();
    chk("oor_r_latency", 32'(rv_cyc - k), 32'd2);
    chk("oor_rresp", 32'(last_rresp), 32'h2);
    chk("oor_rdata", last_rdata, 32'h0);
    exp_write(32'h4000, 32'h1234_5678, 4'hF);
    hs_wr(32'h4000, 32'h1234_5678, 4'hF);
    wait_b();
    chk("oor_bresp", 32'(last_bresp), 32'h2);
    chk("oor_no_en", 32'(en_cnt), 32'(en0));
    exp_read(32'h0);
    hs_ar(32'h0);
    wait_r();
    chk("oor_mem_kept", last_rdata, 32'hA500_0000);

    // back-pressure on R
    rready = 1'b0;
    exp_read(32'h10);
    hs_ar(32'h10);
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 40) begin @(negedge clk); n++; end
    chk("bp_rvalid", 32'(rvalid), 32'h1);
    chk("bp_rdata", rdata, 32'hDEAD_ABEF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_arready_low", 32'(arready), 32'h0);
      chk("bp_rvalid_held", 32'(rvalid), 32'h1);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_arready_back", 32'(arready), 32'h1);
    chk("bp_rvalid_gone", 32'(rvalid), 32'h0);
    @(posedge clk); #1;

    // reset while the read is being issued
    hs_ar(32'h10);
    n = 0;
    @(negedge clk);
    while (!mem_en && n < 20) begin @(negedge clk); n++; end
    chk("abort_issue_seen", 32'(mem_en), 32'h1);
    rst_n = 1'b0;
    rv0 = rv_rises;
    @(negedge clk);
    chk_rst_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("abort_no_rvalid", 32'(rv_rises), 32'(rv0));
    exp_read(32'h10);
    hs_ar(32'h10);
    wait_r();
    chk("after_abort_rd", last_rdata, 32'hDEAD_ABEF);

    // contention from reset: R first, then strict alternation
    do_reset();
    order.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          exp_read(32'h100 + 32'(4 * i));
          hs_ar(32'h100 + 32'(4 * i));
        end
      end
      begin
        for (int j = 0; j < 3; j++) begin
          exp_write(32'h200 + 32'(4 * j), 32'h1111_0000 + 32'(j), 4'hF);
          hs_wr(32'h200 + 32'(4 * j), 32'h1111_0000 + 32'(j), 4'hF);
        end
      end
    join
    n = 0;
    while ((exp_r_q.size() != 0 || exp_b_q.size() != 0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("arb_r_drained", 32'(exp_r_q.size()), 32'h0);
    chk("arb_b_drained", 32'(exp_b_q.size()), 32'h0);
    chk("arb_count", 32'(order.size()), 32'd6);
    for (int i = 0; i < 6 && i < order.size(); i++)
      chk($sformatf("arb_order_%0d", i), 32'(order[i]), 32'(i % 2));
    chk("arb_w_drained", 32'(exp_w_q.size()), 32'h0);
    chk("arb_mem_202", bram[12'h82], 32'h1111_0002);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_lite_bram_responder.md
AXI_LITE_BRAM_RESPONDER -- requirements
Module: axi_lite_bram_responder

Interface
REQ-001 SHALL take parameter BASE_ADDR, default 32'h0000_0000: byte base of the decoded window.
REQ-002 SHALL take parameter MEM_WORDS, default 4096: window size in 32-bit words (16 KB).
REQ-003 SHALL have sys_clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have sys_rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have s_axi_araddr/arvalid/arready  in/in/out  32/1/1  AXI4-Lite read address channel.
REQ-006 SHALL have s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
REQ-007 SHALL have s_axi_awaddr/awvalid/awready  in/in/out  32/1/1  write address channel.
REQ-008 SHALL have s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
REQ-009 SHALL have s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
REQ-010 SHALL have mem_en/mem_we/mem_addr/mem_din  out  1/4/30/32  BRAM port: enable, byte write enables, word address, write data.
REQ-011 SHALL have mem_dout  in  32  BRAM read data, valid the cycle after mem_en=1 with mem_we=0.

Function
REQ-012 SHALL register each of AR, AW and W in its own one-entry hold register; a channel's ready SHALL be 1 only when its hold register is empty and sys_rst_n=1.
REQ-013 SHALL accept AW and W independently, in either order or in the same cycle.
REQ-014 SHALL use FSM states IDLE, WR, RD_ISSUE, RD_CAPTURE, BRESP, RRESP.
REQ-015 In IDLE: write eligible = AW and W both held; read eligible = AR held. If only one is eligible, grant it. If both, grant the kind not granted last. last_grant resets to "write", so the first contention grants the read.
REQ-016 SHALL compute offset = addr - BASE_ADDR (32-bit, wrap permitted). The access is in range when offset[31:2] < MEM_WORDS. offset[1:0] SHALL be ignored.
REQ-017 Write grant at cycle N, in range: during N+1 (state WR), mem_en=1, mem_we=held wstrb, mem_addr=offset[31:2], mem_din=held wdata. bvalid=1 with bresp=2'b00 from N+2 (BRESP).
REQ-018 Write with wstrb=4'b0000 SHALL still assert mem_en with mem_we=0 and respond OKAY.
REQ-019 Read grant at N, in range: mem_en=1, mem_we=0 during N+1 (RD_ISSUE). mem_dout SHALL be registered at the end of N+2 (RD_CAPTURE). rvalid=1, rresp=2'b00 from N+3 (RRESP).
REQ-020 Out-of-range grant SHALL leave mem_en=0 and go straight to BRESP/RRESP at N+1 with resp=2'b10 (SLVERR); rdata=0.
REQ-021 bvalid/rvalid, together with their bresp/rresp and rdata, SHALL hold stable until bready/rready=1. The handshake cycle SHALL release the consumed hold registers and return the FSM to IDLE.
REQ-022 The hold registers SHALL be cleared when the response handshakes, not at grant. At most one transaction SHALL be outstanding.
REQ-023 mem_en SHALL be 0 in every state except WR and RD_ISSUE. mem_we SHALL be 0 outside WR.
REQ-024 bready or rready held high before valid SHALL complete the handshake in the first valid cycle.

Reset
REQ-025 While sys_rst_n=0 at a clock edge: state=IDLE; hold registers empty; last_grant=write; arready=awready=wready=0; bvalid=rvalid=0; bresp=rresp=0; rdata=0; mem_en=0; mem_we=0; mem_addr=0; mem_din=0.
REQ-026 Reset asserted mid-transaction SHALL abort it silently: no response is issued, and no memory write occurs after the reset edge.
REQ-027 Ready outputs SHALL go high in the first cycle after sys_rst_n returns to 1.

Verification
REQ-028 AW=0x10 and W=0xDEADBEEF/strb 4'hF in the same cycle, bready=1 -> mem_we=4'hF, mem_addr=4 two cycles later; bvalid with OKAY one cycle after that; a subsequent read of 0x10 returns 0xDEADBEEF with rresp=0, rvalid 3 cycles after grant.
REQ-029 W presented 3 cycles before AW; wstrb=4'b0010, wdata=0x0000AB00 -> write occurs only after AW is held; byte 1 updates to 0xAB, other bytes unchanged on readback.
REQ-030 Read of BASE_ADDR+4*MEM_WORDS (0x4000) -> mem_en never asserted; rvalid next cycle with rresp=2'b10 and rdata=0. A write to the same address gives bresp=2'b10 and leaves memory unchanged.
REQ-031 AR and AW+W all held in IDLE after reset -> read granted first, then the write. Under continuous traffic on both, grants alternate R,W,R,W.
REQ-032 rready held 0 for 10 cycles -> rvalid/rdata stable and arready=0 throughout; rready=1 -> handshake, then arready=1 the next cycle.
REQ-033 sys_rst_n=0 during RD_ISSUE -> next cycle all outputs at reset values, no rvalid ever issued; a new read after release completes normally.
